// File: rtl/data_mem.sv
// data_mem: word-organised data memory for the load/store path.
// Byte/half/word access with sign or zero extension on loads, one request
// per cycle, one-cycle response with an error flag, and an optional
// post-reset sweep that zeroes the array before the first request.
module data_mem #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clear_idx_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              wr_en;
  logic [3:0]        be;
  logic [31:0]       wdata_lanes;
  logic [31:0]       rd_shift;
  logic [31:0]       rsp_rdata_d;

  assign word_idx     = req_addr[ADDR_W+1:2];
  assign lane         = req_addr[1:0];
  // Any address bit above the array is an error; addresses never alias.
  assign out_of_range = (req_addr >> (ADDR_W + 2)) != 32'd0;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & lane[0])
                 | ((req_size == 2'b10) & (lane != 2'b00))
                 | out_of_range;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_CLEAR);
  assign accept    = req_valid & req_ready;
  assign wr_en     = accept & req_write & ~req_err;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Store byte enables and lane replication of right-aligned store data
  always_comb begin
    be          = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        be          = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be          = 4'b0011 << lane;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load path: pick the lane and extend; zero for stores and errors
  always_comb begin
    rd_shift    = mem_q[word_idx] >> {lane, 3'b000};
    rsp_rdata_d = 32'd0;
    if (accept && !req_write && !req_err) begin
      case (req_size)
        2'b00:   rsp_rdata_d = req_unsigned ? {24'd0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
        2'b01:   rsp_rdata_d = req_unsigned ? {16'd0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
        default: rsp_rdata_d = rd_shift;
      endcase
    end
  end

  // Array writes: the clear sweep, or an accepted error-free store.
  // No reset here so contents survive reset when clearing is disabled.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_CLEAR) begin
      mem_q[clear_idx_q] <= 32'd0;
    end else if (!rst && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clear_idx_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clear_idx_q <= clear_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (&clear_idx_q) state_q <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          rsp_valid_q <= accept;
          rsp_err_q   <= accept & req_err;
          rsp_rdata_q <= rsp_rdata_d;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Testbench for data_mem with ADDR_W=4 (16 words, 64 bytes) and clearing on.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  data_mem #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (byte array, spec rules) ----------------
  logic [7:0]  mem_m [64];
  int          clear_cnt = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic        exp_err = 1'b0;

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] s);
    int n;
    if (s == 2'b11) return 1'b1;
    n = 1 << s;
    if (a >= 32'd64) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s,
                                         input logic u);
    int n;
    logic [31:0] v;
    n = 1 << s;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[int'(a[5:0]) + k]) << (8 * k));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_cnt <= 0;
      exp_valid <= 1'b0;
      exp_rdata <= 32'd0;
      exp_err   <= 1'b0;
    end else if (clear_cnt < 16) begin
      clear_cnt <= clear_cnt + 1;
      exp_valid <= 1'b0;
      if (clear_cnt == 15) for (int i = 0; i < 64; i++) mem_m[i] <= 8'h00;
    end else begin
      exp_valid <= req_valid;
      exp_err   <= req_valid && m_err(req_addr, req_size);
      exp_rdata <= (req_valid && !req_write && !m_err(req_addr, req_size))
                   ? m_load(req_addr, req_size, req_unsigned) : 32'd0;
      if (req_valid && req_write && !m_err(req_addr, req_size))
        for (int k = 0; k < (1 << req_size); k++)
          mem_m[int'(req_addr[5:0]) + k] <= req_wdata[8*k +: 8];
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'd0, req_ready}, {31'd0, clear_cnt >= 16});
      chk("busy", {31'd0, busy}, {31'd0, clear_cnt < 16});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
    end
  end

  // Drive one request (called at posedge+1), accept at next edge, check literals
  task automatic issue(input string nm, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    chk({nm, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, ".rdata"}, rsp_rdata, er);
    chk({nm, ".err"}, {31'd0, rsp_err}, {31'd0, ee});
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int n;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd1);
    chk("rst.ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("clear.busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("clear.done_ready", {31'd0, req_ready}, 32'd1);
    chk("clear.done_busy", {31'd0, busy}, 32'd0);

    // Whole array reads back zero
    for (int i = 0; i < 16; i++)
      issue("clr_load", 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'd0, 32'd0, 1'b0);

    // Store then extended loads
    issue("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_80F0, 32'd0, 1'b0);
    issue("lb_s10", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'hFFFF_FFF0, 1'b0);
    issue("lb_u11", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'h0000_0080, 1'b0);
    issue("lh_s12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF_8000, 1'b0);
    issue("lh_u12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h0000_8000, 1'b0);

    // Partial stores
    issue("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
    issue("st_b21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA, 32'd0, 1'b0);
    issue("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 32'd0, 1'b0);
    issue("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'hBEEF_AA44, 1'b0);
    idle();

    // Errors: no write, err=1, rdata=0
    issue("err_h03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_FFFF, 32'd0, 1'b1);
    issue("err_w06", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue("err_sz3", 1'b1, 2'b11, 1'b0, 32'h20, 32'h5555_5555, 32'd0, 1'b1);
    issue("err_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 32'd0, 1'b1);
    issue("err_ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
    issue("err_ld_h03", 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
    issue("unch_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 32'd0, 1'b0);
    issue("unch_w04", 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, 32'd0, 1'b0);
    issue("unch_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'hBEEF_AA44, 1'b0);
    idle();

    // Read-after-write on consecutive edges
    issue("raw_st", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue("raw_ld", 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 32'hDEAD_BEEF, 1'b0);
    idle();

    // Continuous valid for 8 cycles
    pulses = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'(4 * i);
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk("b2b.pulses", 32'(pulses), 32'd8);
    idle();
    chk("b2b.after_idle", {31'd0, rsp_valid}, 32'd0);

    // Reset with a response in flight drops it at once
    issue("pre_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'hBEEF_AA44, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_inflight.valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_inflight.rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("midclr.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midclr.valid", {31'd0, rsp_valid}, 32'd0);
    chk("midclr.ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Request held through the restarted clear
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midclr.edges", 32'(n), 32'd16);
    @(posedge clk); #1;
    chk("held.valid", {31'd0, rsp_valid}, 32'd1);
    chk("held.rdata", rsp_rdata, 32'd0);
    chk("held.err", {31'd0, rsp_err}, 32'd0);
    idle();
    idle();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised, word-organised data memory for the CPU load/store path, with byte/half/word access and sign or zero extension on loads. It accepts one request per cycle through a valid/ready handshake and returns a one-cycle-latency response that carries an error flag for misaligned or out-of-range accesses. An optional post-reset clear sequencer zeroes the whole array before the first request is accepted. It sits between the execute/memory stage and the register-file writeback.

## Interface
- ADDR_W, 10, word-address bits; depth is DEPTH = 2**ADDR_W 32-bit words
- CLEAR_ON_RESET, 1, 1 means zero every word after reset; 0 means the array contents after reset are undefined
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored on stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response strobe, one cycle per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  accepted request was illegal; no array change
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLEAR and IDLE. Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR:
  - Writes 0 to word clear_idx on each rising edge, then increments clear_idx.
  - On the edge that writes word DEPTH-1, the FSM goes to IDLE.
  - req_ready=0 and busy=1 throughout CLEAR.
- IDLE: req_ready=1 and busy=0. A request is accepted on a rising edge where req_valid && req_ready.
- Word index is req_addr[ADDR_W+1:2]; lane is req_addr[1:0].
- Error conditions, any of:
  - req_size==11
  - half access with lane[0]=1
  - word access with lane!=0
  - req_addr[31:ADDR_W+2] != 0
- On error: no write, rsp_err=1, rsp_rdata=0.
- Store, byte enables:
  - byte: lane-selected byte gets req_wdata[7:0]
  - half: lanes {lane+1, lane} get req_wdata[15:0]
  - word: all four lanes get req_wdata
  - Bytes not enabled are preserved. A store response has rsp_rdata=0 and rsp_err=0.
- Load:
  - Read the word, select the byte or half at the lane, extend to 32 bits according to req_unsigned.
  - Word loads return the word unchanged.
- There is exactly one response per accepted request, in order. There is no response backpressure.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, clear_idx=0.
  - busy=1 and req_ready=0 when CLEAR_ON_RESET=1.
  - busy=0 and req_ready=1 when CLEAR_ON_RESET=0.
- Clear duration: exactly DEPTH rising edges after rst deasserts. req_ready rises after the DEPTH-th edge.
- Latency: a request accepted at edge N gives rsp_valid=1 from edge N to edge N+1. rsp_rdata and rsp_err are valid in that same window.
- rsp_valid is 0 in any cycle that follows an edge with no accepted request.
- Throughput: one request per cycle in IDLE, with back-to-back accepts allowed.
- Read-after-write: a load accepted at edge N+1 to the same word as a store accepted at edge N returns the stored data.
- Requests presented during CLEAR are not accepted and are not lost. The requester holds req_valid until req_ready.
- rst asserted mid-operation: outputs return to their reset values immediately and any in-flight response is dropped.
  - With CLEAR_ON_RESET=1, the clear restarts from word 0.
  - With CLEAR_ON_RESET=0, array contents are retained.
- Word index wrap does not occur. Addresses beyond DEPTH words are reported as errors, never aliased.

## Test plan
Use ADDR_W=4 (DEPTH=16).

- Clear: reset with CLEAR_ON_RESET=1 -> busy=1 for 16 edges, req_ready rises after the 16th edge; a word load of every address 0x00..0x3C returns 0.
- Store then extended loads:
  - Store word 0x8000_80F0 @0x10.
  - Load byte signed @0x10 -> 0xFFFF_FFF0.
  - Load byte unsigned @0x11 -> 0x0000_0080.
  - Load half signed @0x12 -> 0xFFFF_8000.
- Partial stores:
  - Store word 0x1122_3344 @0x20.
  - Store byte 0xAA @0x21.
  - Store half 0xBEEF @0x22.
  - Load word @0x20 -> 0xBEEF_AA44.
- Errors, each giving rsp_err=1, rsp_rdata=0, and memory unchanged:
  - half @0x03
  - word @0x06
  - req_size=11
  - word @0x40 (out of range)
- Back-to-back:
  - Store word 0xDEAD_BEEF @0x08 at edge N, load word @0x08 at edge N+1 -> rsp_rdata=0xDEAD_BEEF at N+1.
  - Continuous valid for 8 cycles gives 8 consecutive rsp_valid pulses.
- Mid-clear reset: assert rst after 5 clear edges -> rsp_valid=0 immediately, and the clear restarts to take a full 16 edges after release. A request held during the clear is accepted on the first cycle with req_ready=1.
